// File: rtl/alu_iter.sv
// Slice-serial ALU: executes the decoder's 3-bit ALUControl op over WIDTH/SLICE cycles
// using a single SLICE-bit adder, with a start/busy/done handshake.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic             invert_b;
    logic [SLICE-1:0] a_s, b_eff, slice_res;
    logic [SLICE:0]   sum_ext;
    logic             cin_msb, overflow, lt;
    logic             is_illegal;
    logic [WIDTH-1:0] acc_shifted, final_res;

    // Datapath for the current slice; operands sit in shift registers so slice i is always at the LSBs.
    always_comb begin
        invert_b   = (op_q == OP_SUB) || (op_q == OP_SLT);
        is_illegal = op_q[2] & op_q[1];
        a_s        = a_q[SLICE-1:0];
        b_eff      = invert_b ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
        sum_ext    = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        cin_msb    = sum_ext[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];
        overflow   = cin_msb ^ sum_ext[SLICE];
        lt         = sum_ext[SLICE-1] ^ overflow;

        case (op_q)
            OP_ADD, OP_SUB, OP_SLT: slice_res = sum_ext[SLICE-1:0];
            OP_AND:                 slice_res = a_s & b_eff;
            OP_OR:                  slice_res = a_s | b_eff;
            OP_XOR:                 slice_res = a_s ^ b_eff;
            default:                slice_res = '0;
        endcase

        acc_shifted = WIDTH'({slice_res, acc_q} >> SLICE);

        if (is_illegal)
            final_res = '0;
        else if (op_q == OP_SLT)
            final_res = {{(WIDTH-1){1'b0}}, lt};
        else
            final_res = acc_shifted;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    op_d    = ALUControl;
                    a_d     = SrcA;
                    b_d     = SrcB;
                    carry_d = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                acc_d   = acc_shifted;
                carry_d = sum_ext[SLICE];
                idx_d   = idx_q + IW'(1);
                // Final slice: publish all result flags together so they never disagree.
                if (idx_q == IW'(N-1)) begin
                    state_d   = IDLE;
                    result_d  = final_res;
                    zero_d    = (final_res == '0);
                    illegal_d = is_illegal;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases plus random ops compared
// against a plain-arithmetic reference model.
module tb_alu_iter;

    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             illegal;

    int checks;
    int errors;
    int overlapCount;
    int doneSeen;

    alu_iter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ALUControl(ALUControl),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .busy(busy),
        .done(done),
        .ALUResult(ALUResult),
        .Zero(Zero),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track done/busy overlap and done pulses independently of the main sequence.
    always @(negedge clk) begin
        if (done && busy) overlapCount++;
        if (done) doneSeen++;
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] refResult(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        ALUControl = 3'($urandom_range(0, 7));
        SrcA       = $urandom;
        SrcB       = $urandom;
    endtask

    // seen = busy cycles already observed; leaves us at the negedge of the done cycle.
    task automatic waitDone(input string tag, input int seen, input logic [2:0] op,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int cnt;
        logic [WIDTH-1:0] expRes;
        cnt = seen;
        while (cnt < 4 * N) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        expRes = refResult(op, a, b);
        checkOutput({tag, ".busyCycles"}, WIDTH'(cnt), WIDTH'(N));
        checkOutput({tag, ".done"}, WIDTH'(done), 1);
        checkOutput({tag, ".result"}, ALUResult, expRes);
        checkOutput({tag, ".zero"}, WIDTH'(Zero), WIDTH'(expRes == '0));
        checkOutput({tag, ".illegal"}, WIDTH'(illegal), WIDTH'(op[2] & op[1]));
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        applyStimulus(op, a, b);
        waitDone(tag, 1, op, a, b);
    endtask

    initial begin
        logic [2:0]       rop;
        logic [WIDTH-1:0] ra, rb, held;
        int               doneBefore;

        checks       = 0;
        errors       = 0;
        overlapCount = 0;
        doneSeen     = 0;
        reset        = 1'b1;
        start        = 1'b0;
        ALUControl   = 3'd0;
        SrcA         = '0;
        SrcB         = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset.busy", WIDTH'(busy), 0);
        checkOutput("reset.done", WIDTH'(done), 0);
        checkOutput("reset.result", ALUResult, 0);
        checkOutput("reset.zero", WIDTH'(Zero), 1);
        checkOutput("reset.illegal", WIDTH'(illegal), 0);
        reset = 1'b0;
        @(negedge clk);

        runOp("add", 3'd0, 32'd5, 32'd7);
        held = ALUResult;
        @(negedge clk);
        checkOutput("add.doneDrop", WIDTH'(done), 0);
        checkOutput("add.hold", ALUResult, held);

        runOp("sub", 3'd1, 32'd3, 32'd5);
        runOp("subZero", 3'd1, 32'h12345678, 32'h12345678);
        runOp("sltOvf", 3'd5, 32'h80000000, 32'd1);
        runOp("sltPosNeg", 3'd5, 32'd1, 32'h80000000);
        runOp("sltNeg", 3'd5, 32'hFFFFFFFF, 32'd0);
        runOp("and", 3'd2, 32'hF0F0A5A5, 32'h0FF0FFFF);
        runOp("or", 3'd3, 32'hF0F0A5A5, 32'h0FF0FFFF);
        runOp("xor", 3'd4, 32'hF0F0A5A5, 32'h0FF0FFFF);
        checkOutput("xor.literal", ALUResult, 32'hFF005A5A);

        // start pulsed in RUN cycle 3 must be ignored; start on the done cycle is accepted.
        applyStimulus(3'd0, 32'd100, 32'd23);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; ALUControl = 3'd1; SrcA = 32'hDEAD; SrcB = 32'h1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignoreStart", 4, 3'd0, 32'd100, 32'd23);
        runOp("backToBack", 3'd4, 32'h0F0F0F0F, 32'h00FF00FF);

        // Reset in RUN cycle 4 discards the op with no done.
        applyStimulus(3'd0, 32'd1, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midReset.busy", WIDTH'(busy), 0);
        checkOutput("midReset.result", ALUResult, 0);
        checkOutput("midReset.zero", WIDTH'(Zero), 1);
        checkOutput("midReset.done", WIDTH'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        doneBefore = doneSeen;
        repeat (2 * N) @(negedge clk);
        checkOutput("midReset.noDone", WIDTH'(doneSeen - doneBefore), 0);

        runOp("illegal110", 3'b110, 32'h1234, 32'h5678);
        runOp("illegal111", 3'b111, 32'hFFFFFFFF, 32'h1);
        runOp("afterIllegal", 3'd0, 32'hFFFFFFFF, 32'd1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 32'h80000000;
            runOp($sformatf("rand%0d", i), rop, ra, rb);
        end

        checkOutput("doneBusyOverlap", WIDTH'(overlapCount), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
